// File: rtl/wt_fetch_pkg.sv
// Shared types and helpers for the weight-SRAM fetch controller.
// The build macro WT_FETCH_RR_EN (see wt_fetch_arb) selects round-robin arbitration.
package wt_fetch_pkg;

    localparam int DEF_NUM_LAYERS = 5;
    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_DATA_W     = 72;
    localparam int DEF_LEN_W      = 4;
    localparam int DEF_LID_W      = 3;

    // Widest packed cfg vector the field extractor accepts
    localparam int CFG_VEC_W = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] cfg_field(input logic [CFG_VEC_W-1:0] vec,
                                              input int width,
                                              input int idx);
        logic [CFG_VEC_W-1:0] shifted;
        logic [31:0]          mask;
        shifted = vec >> (idx * width);
        mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return shifted[31:0] & mask;
    endfunction

endpackage

// File: rtl/wt_fetch_arb.sv
// Pending-vector arbiter: one-hot grant plus index.
// WT_FETCH_RR_EN defined -> round-robin from (i_last+1); undefined -> lowest index wins.
module wt_fetch_arb
    import wt_fetch_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int LID_W      = DEF_LID_W
) (
    input  logic [NUM_LAYERS-1:0] i_pending,
    input  logic [LID_W-1:0]      i_last,
    output logic [NUM_LAYERS-1:0] o_grant_oh,
    output logic [LID_W-1:0]      o_grant_idx,
    output logic                  o_grant_vld
);

`ifdef WT_FETCH_RR_EN
    // Walk the ring once starting after the last winner; first pending layer takes it
    always_comb begin
        int j;
        j           = 0;
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            j = int'(i_last) + 1 + k;
            if (j >= NUM_LAYERS) j = j - NUM_LAYERS;
            if (j >= NUM_LAYERS) j = j - NUM_LAYERS;
            if (!o_grant_vld && (|(i_pending & (NUM_LAYERS'(1) << j)))) begin
                o_grant_vld = 1'b1;
                o_grant_oh  = NUM_LAYERS'(1) << j;
                o_grant_idx = LID_W'(j);
            end
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^i_last;

    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (|(i_pending & (NUM_LAYERS'(1) << k))) begin
                o_grant_vld = 1'b1;
                o_grant_oh  = NUM_LAYERS'(1) << k;
                o_grant_idx = LID_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/wt_fetch_ctrl.sv
// Weight SRAM fetch controller: external writes plus arbitrated per-layer burst reads.
// Define WT_FETCH_RR_EN for round-robin arbitration instead of fixed priority.
module wt_fetch_ctrl
    import wt_fetch_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int LID_W      = DEF_LID_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         write_en,
    input  logic [ADDR_W-1:0]            addr_w,
    input  logic                         clr_i,
    input  logic [NUM_LAYERS-1:0]        layer_req_i,
    input  logic [NUM_LAYERS*ADDR_W-1:0] cfg_base_i,
    input  logic [NUM_LAYERS*LEN_W-1:0]  cfg_len_i,
    input  logic [DATA_W-1:0]            data_r,
    output logic [ADDR_W-1:0]            addr,
    output logic                         me,
    output logic                         we,
    output logic                         wt_valid_o,
    output logic [DATA_W-1:0]            wt_data_o,
    output logic [LID_W-1:0]             wt_layer_o,
    output logic [LEN_W-1:0]             wt_idx_o,
    output logic [NUM_LAYERS-1:0]        layer_rdy_o,
    output logic                         busy_o
);

    fetch_state_t            r_state, w_state_nxt;
    logic [NUM_LAYERS-1:0]   r_pending, w_pending_nxt;
    logic [NUM_LAYERS-1:0]   w_grant_oh;
    logic [LID_W-1:0]        w_grant_idx;
    logic                    w_grant_vld, w_grant;
    logic [LID_W-1:0]        r_layer, r_last;
    logic [ADDR_W-1:0]       r_base, w_base_sel;
    logic [LEN_W-1:0]        r_len, r_idx, w_len_sel;
    logic                    w_rd_issue, w_last_rd;
    logic                    r_out_valid;
    logic [LID_W-1:0]        r_out_layer;
    logic [LEN_W-1:0]        r_out_idx;

    wt_fetch_arb #(
        .NUM_LAYERS (NUM_LAYERS),
        .LID_W      (LID_W)
    ) u_arb (
        .i_pending   (r_pending),
        .i_last      (r_last),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld)
    );

    assign w_grant    = (r_state == IDLE) && w_grant_vld;
    assign w_base_sel = ADDR_W'(cfg_field(CFG_VEC_W'(cfg_base_i), ADDR_W, int'(w_grant_idx)));
    assign w_len_sel  = LEN_W'(cfg_field(CFG_VEC_W'(cfg_len_i), LEN_W, int'(w_grant_idx)));
    assign w_last_rd  = (r_idx == r_len - LEN_W'(1));

    // A request landing in its own grant cycle re-arms the bit; clear beats both
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_grant) w_pending_nxt = w_pending_nxt & ~w_grant_oh;
        w_pending_nxt = w_pending_nxt | layer_req_i;
        if (clr_i) w_pending_nxt = '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_issue  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) w_state_nxt = (w_len_sel == '0) ? DRAIN : READ;
            end
            READ: begin
                if (!write_en) begin
                    w_rd_issue = 1'b1;
                    if (w_last_rd) w_state_nxt = DRAIN;
                end
            end
            DRAIN:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // External writes always own the single SRAM port
    always_comb begin
        addr = '0;
        me   = 1'b0;
        we   = 1'b0;
        if (write_en) begin
            addr = addr_w;
            me   = 1'b1;
            we   = 1'b1;
        end else if (w_rd_issue) begin
            addr = r_base + ADDR_W'(r_idx);
            me   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_layer     <= '0;
            r_last      <= LID_W'(NUM_LAYERS - 1);
            r_base      <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_layer <= '0;
            r_out_idx   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            if (w_grant) begin
                r_layer <= w_grant_idx;
                r_last  <= w_grant_idx;
                r_base  <= w_base_sel;
                r_len   <= w_len_sel;
                r_idx   <= '0;
            end else if (w_rd_issue && !w_last_rd) begin
                r_idx <= r_idx + LEN_W'(1);
            end
            r_out_valid <= w_rd_issue;
            if (w_rd_issue) begin
                r_out_layer <= r_layer;
                r_out_idx   <= r_idx;
            end
        end
    end

    always_comb begin
        layer_rdy_o = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            layer_rdy_o[i] = (r_state == DRAIN) && (r_layer == LID_W'(i));
        end
    end

    assign wt_valid_o = r_out_valid;
    assign wt_data_o  = data_r;
    assign wt_layer_o = r_out_layer;
    assign wt_idx_o   = r_out_idx;
    assign busy_o     = (r_state != IDLE) || w_grant;

endmodule

// File: tb/tb_wt_fetch_ctrl.sv
// Self-checking bench for wt_fetch_ctrl with an SRAM model and a word/ready scoreboard.
// Honours WT_FETCH_RR_EN for the arbitration-order test.
module tb_wt_fetch_ctrl;

    localparam int NL = 5;
    localparam int AW = 10;
    localparam int DW = 72;
    localparam int LW = 4;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            write_en = 1'b0;
    logic [AW-1:0]   addr_w = '0;
    logic            clr_i = 1'b0;
    logic [NL-1:0]   layer_req_i = '0;
    logic [NL*AW-1:0] cfg_base_i = '0;
    logic [NL*LW-1:0] cfg_len_i = '0;
    logic [DW-1:0]   data_r = '0;
    logic [AW-1:0]   addr;
    logic            me, we;
    logic            wt_valid_o;
    logic [DW-1:0]   wt_data_o;
    logic [IW-1:0]   wt_layer_o;
    logic [LW-1:0]   wt_idx_o;
    logic [NL-1:0]   layer_rdy_o;
    logic            busy_o;

    logic [DW-1:0]   wdata = '0;
    logic [DW-1:0]   mem    [0:(1<<AW)-1];
    logic [DW-1:0]   shadow [0:(1<<AW)-1];

    logic [IW+LW+DW-1:0] expWordQ[$];
    int                  expRdyQ[$];
    logic [AW-1:0]       rdAddrQ[$];

    int nChecks = 0;
    int nErrors = 0;
    int first, second;

    wt_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .addr_w(addr_w), .clr_i(clr_i),
        .layer_req_i(layer_req_i), .cfg_base_i(cfg_base_i), .cfg_len_i(cfg_len_i),
        .data_r(data_r), .addr(addr), .me(me), .we(we), .wt_valid_o(wt_valid_o),
        .wt_data_o(wt_data_o), .wt_layer_o(wt_layer_o), .wt_idx_o(wt_idx_o),
        .layer_rdy_o(layer_rdy_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (me && we) mem[addr] <= wdata;
        else if (me)  data_r    <= mem[addr];
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: words and ready pulses pop against queued expectations
    always @(negedge clk) begin
        if (rst_n) begin
            if (me && !we) rdAddrQ.push_back(addr);
            if (wt_valid_o) begin
                if (expWordQ.size() == 0) checkOutput("unexpected word", 128'(wt_idx_o), 128'hDEAD);
                else checkOutput("word", 128'({wt_layer_o, wt_idx_o, wt_data_o}), 128'(expWordQ.pop_front()));
            end
            if (layer_rdy_o != '0) begin
                if (expRdyQ.size() == 0) checkOutput("unexpected rdy", 128'(layer_rdy_o), 128'h0);
                else checkOutput("rdy", 128'(layer_rdy_o), 128'(NL'(1) << expRdyQ.pop_front()));
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic writeWord(input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_en = 1'b1;
        addr_w   = a;
        wdata    = d;
        shadow[a] = d;
        nextCycle();
        write_en = 1'b0;
    endtask

    // Configure a layer, queue its expected burst and raise its request bit
    task automatic applyStimulus(input int layer, input logic [AW-1:0] base, input logic [LW-1:0] len);
        cfg_base_i[layer*AW +: AW] = base;
        cfg_len_i[layer*LW +: LW]  = len;
        for (int i = 0; i < int'(len); i++) begin
            expWordQ.push_back({IW'(layer), LW'(i), shadow[AW'(int'(base) + i)]});
        end
        expRdyQ.push_back(layer);
        layer_req_i[layer] = 1'b1;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (n < 40 && (busy_o || expWordQ.size() != 0 || expRdyQ.size() != 0)) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 128'({busy_o, 8'(expWordQ.size()), 8'(expRdyQ.size())}), 128'h0);
        nextCycle();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #2;
        checkOutput("reset outputs", 128'({addr, me, we, wt_valid_o, wt_layer_o, wt_idx_o, layer_rdy_o, busy_o}), 128'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        nextCycle();

        // Test 1: basic len=4 burst on layer 1
        for (int i = 0; i < 4; i++) writeWord(AW'(16 + i), DW'(8'hA0 + i));
        nextCycle();
        applyStimulus(1, 10'h010, 4'd4);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput("t1 busy", 128'(busy_o), 128'(c >= 1 && c <= 6));
            checkOutput("t1 valid", 128'(wt_valid_o), 128'(c >= 3 && c <= 6));
            checkOutput("t1 me", 128'(me), 128'(c >= 2 && c <= 5));
            checkOutput("t1 rdy", 128'(layer_rdy_o), (c == 6) ? 128'h2 : 128'h0);
            nextCycle();
            layer_req_i = '0;
        end
        waitIdle("t1 idle");

        // Test 2: simultaneous requests on layers 0 and 3
        for (int i = 0; i < 2; i++) begin
            writeWord(AW'(32 + i), DW'(8'hB0 + i));
            writeWord(AW'(48 + i), DW'(8'hC0 + i));
        end
`ifdef WT_FETCH_RR_EN
        first = 3; second = 0;
`else
        first = 0; second = 3;
`endif
        nextCycle();
        applyStimulus(first, (first == 0) ? 10'h020 : 10'h030, 4'd2);
        applyStimulus(second, (second == 0) ? 10'h020 : 10'h030, 4'd2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("t2 valid", 128'(wt_valid_o), 128'(c == 3 || c == 4 || c == 7 || c == 8));
            checkOutput("t2 rdy", 128'(layer_rdy_o),
                        (c == 4) ? 128'(NL'(1) << first) : (c == 8) ? 128'(NL'(1) << second) : 128'h0);
            nextCycle();
            layer_req_i = '0;
        end
        waitIdle("t2 idle");

        // Test 3: two external writes stall the second read
        applyStimulus(1, 10'h010, 4'd4);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("t3 valid", 128'(wt_valid_o), 128'(c == 3 || (c >= 6 && c <= 8)));
            checkOutput("t3 port", 128'({we, me, addr}),
                        (c == 3) ? 128'({2'b11, 10'h100}) :
                        (c == 4) ? 128'({2'b11, 10'h101}) :
                        (c == 2 || (c >= 5 && c <= 7)) ? 128'({2'b01, AW'(16 + ((c == 2) ? 0 : c - 4))}) :
                        128'h0);
            checkOutput("t3 rdy", 128'(layer_rdy_o), (c == 8) ? 128'h2 : 128'h0);
            nextCycle();
            layer_req_i = '0;
            write_en = (c + 1 == 3) || (c + 1 == 4);
            addr_w   = AW'(10'h100 + ((c + 1 == 4) ? 1 : 0));
            wdata    = DW'(8'h55 + ((c + 1 == 4) ? 1 : 0));
            if (write_en) shadow[addr_w] = wdata;
        end
        write_en = 1'b0;
        waitIdle("t3 idle");

        // Test 4: zero-length burst on layer 2
        applyStimulus(2, 10'h040, 4'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("t4 me", 128'(me), 128'h0);
            checkOutput("t4 valid", 128'(wt_valid_o), 128'h0);
            checkOutput("t4 rdy", 128'(layer_rdy_o), (c == 2) ? 128'h4 : 128'h0);
            nextCycle();
            layer_req_i = '0;
        end
        waitIdle("t4 idle");

        // Test 5: address wrap at the top of the SRAM
        writeWord(10'h3FE, 72'hD0);
        writeWord(10'h3FF, 72'hD1);
        writeWord(10'h000, 72'hD2);
        nextCycle();
        rdAddrQ.delete();
        applyStimulus(4, 10'h3FE, 4'd3);
        nextCycle();
        layer_req_i = '0;
        waitIdle("t5 idle");
        checkOutput("t5 nreads", 128'(rdAddrQ.size()), 128'd3);
        if (rdAddrQ.size() == 3) begin
            checkOutput("t5 addr0", 128'(rdAddrQ[0]), 128'h3FE);
            checkOutput("t5 addr1", 128'(rdAddrQ[1]), 128'h3FF);
            checkOutput("t5 addr2", 128'(rdAddrQ[2]), 128'h000);
        end

        // Test 6a: clear drops pending layer 4 while layer 1 finishes
        applyStimulus(1, 10'h010, 4'd4);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checkOutput("t6 rdy", 128'(layer_rdy_o), (c == 6) ? 128'h2 : 128'h0);
            if (c >= 7) checkOutput("t6 quiet", 128'({busy_o, wt_valid_o}), 128'h0);
            nextCycle();
            layer_req_i = (c + 1 == 2) ? 5'b10000 : 5'b00000;
            clr_i = (c + 1 == 3);
        end
        clr_i = 1'b0;
        waitIdle("t6 idle");

        // Test 6b: asynchronous reset in the middle of a burst
        applyStimulus(1, 10'h010, 4'd4);
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            layer_req_i = '0;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset outputs",
                    128'({addr, me, we, wt_valid_o, wt_layer_o, wt_idx_o, layer_rdy_o, busy_o}), 128'h0);
        expWordQ.delete();
        expRdyQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("post reset idle", 128'({busy_o, wt_valid_o, me}), 128'h0);
        end

        checkOutput("sb drained", 128'({8'(expWordQ.size()), 8'(expRdyQ.size())}), 128'h0);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
